// File: rtl/logicnet_pkg.sv
// Shared constants, helpers and types for the LogicNet layer datapath.
// Widths here describe the layer-1 activation interface.
package logicnet_pkg;

  localparam int LAYER1_IN_W = 256;
  localparam int CHUNK_W     = 32;

  function automatic int beats(input int in_w, input int chunk_w);
    return in_w / chunk_w;
  endfunction

  typedef logic [CHUNK_W-1:0] act_chunk_t;

endpackage

// File: rtl/logicnet_layer_input_packer.sv
// Collects CHUNK_W-bit activation beats into a full IN_W-bit vector and holds it
// stable in an output register for the layer-1 neuron ROMs; one spare slot buffers the next frame.
module logicnet_layer_input_packer
  import logicnet_pkg::*;
#(
  parameter int IN_W    = LAYER1_IN_W,
  parameter int CHUNK_W = logicnet_pkg::CHUNK_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               s_valid,
  output logic               s_ready,
  input  logic [CHUNK_W-1:0] s_data,
  input  logic               s_last,
  output logic               m_valid,
  input  logic               m_ready,
  output logic [IN_W-1:0]    m_vec,
  output logic               frm_err
);

  localparam int BEATS = beats(IN_W, CHUNK_W);
  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

  generate
    if ((IN_W % CHUNK_W) != 0 || BEATS < 1) begin : g_bad_width
      $error("IN_W must be a positive integer multiple of CHUNK_W");
    end
  endgenerate

  logic [CNT_W-1:0] cnt;
  logic [IN_W-1:0]  asm_buf;
  logic [IN_W-1:0]  merged;
  logic             asm_full;
  logic             accept;
  logic             last_slot;
  logic             complete;
  logic             err;
  logic             pop;
  logic             slot_free;

  // s_ready comes straight from a flop, so m_ready never reaches it combinationally
  assign s_ready   = !asm_full;
  assign accept    = s_valid && s_ready;
  assign last_slot = (cnt == CNT_W'(BEATS - 1));
  assign complete  = accept && last_slot && s_last;
  assign err       = accept && (s_last != last_slot);
  assign pop       = m_valid && m_ready;
  assign slot_free = !m_valid || m_ready;

  always_comb begin
    merged = asm_buf;
    for (int k = 0; k < BEATS; k++) begin
      if (cnt == CNT_W'(k)) merged[k*CHUNK_W +: CHUNK_W] = s_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt      <= '0;
      asm_buf  <= '0;
      asm_full <= 1'b0;
      m_valid  <= 1'b0;
      m_vec    <= '0;
      frm_err  <= 1'b0;
    end else begin
      frm_err <= err;
      if (accept) begin
        asm_buf <= merged;
        cnt     <= (last_slot || s_last) ? '0 : cnt + CNT_W'(1);
      end
      // A buffered frame implies m_valid is already high, so a pop simply refills the slot
      if (asm_full) begin
        if (m_ready) begin
          m_vec    <= asm_buf;
          asm_full <= 1'b0;
        end
      end else if (complete && slot_free) begin
        m_vec   <= merged;
        m_valid <= 1'b1;
      end else if (complete) begin
        asm_full <= 1'b1;
      end else if (pop) begin
        m_valid <= 1'b0;
      end
    end
  end

endmodule
